// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared definitions for the processor feeder: word width,
//               opcode encodings and the feeder state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Instruction/data word width (IIIXXXYYY, opcode in the top three bits)
  localparam int unsigned c_DATA_W = 9;

  // Opcodes understood by the processor
  localparam logic [2:0] c_OP_MV  = 3'b000;
  localparam logic [2:0] c_OP_MVI = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b011;

  // Feeder sequencing states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_I  = 3'd1,
    S_LATCH_I  = 3'd2,
    S_FETCH_D  = 3'd3,
    S_LATCH_D  = 3'd4,
    S_ISSUE    = 3'd5,
    S_WAIT     = 3'd6,
    S_FINISHED = 3'd7
  } feeder_state_e;

  // True for opcodes with the top bit set; the processor never returns
  // Done for these, so the feeder skips them without issuing.
  function automatic logic op_unsupported(input logic [2:0] op);
    return op[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_feeder_if
// Description : Feeder-side buses: program ROM read port (MemAddr/MemData)
//               and processor issue port (DIN/Run/Done). The master modport
//               is the feeder; the slave modport is the ROM + processor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_feeder_if
  import proc_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = c_DATA_W
);

  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;

  modport master (
    output MemAddr,
    output DIN,
    output Run,
    input  MemData,
    input  Done
  );

  modport slave (
    input  MemAddr,
    input  DIN,
    input  Run,
    output MemData,
    output Done
  );

endinterface
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_counter
// Description : Program counter for the feeder. Synchronous load-zero,
//               increment that saturates at PROG_LEN-1, and a terminal-count
//               flag at the last program address.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_counter #(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32
) (
  input  wire               Clock,
  input  wire               Resetn,
  input  wire               i_clr,
  input  wire               i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(PROG_LEN - 1);

  logic [ADDR_W-1:0] r_pc;
  logic              w_tc;

  assign w_tc = (r_pc == c_LAST);

  // PC register: clear has priority, increment stops at the last address
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc <= '0;
    end else if (i_clr) begin
      r_pc <= '0;
    end else if (i_inc && !w_tc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;
  assign o_tc = w_tc;

endmodule
`default_nettype wire

// File: rtl/proc_feeder.sv
`default_nettype none
// ============================================================================
// Module      : proc_feeder
// Description : Instruction issuer between program ROM and processor. Walks
//               the program, fetches each word (plus the immediate for mvi),
//               pulses Run with the instruction on DIN, then holds the
//               immediate (or zero) on DIN until the processor returns Done.
//               Unsupported opcodes (1xx) are skipped without issue.
//               Optional build macro FEEDER_DONE_TIMEOUT_EN adds a Done
//               watchdog and the sticky TimeoutErr output.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_feeder
  import proc_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int PROG_LEN = 32,
  parameter int DATA_W   = c_DATA_W,
  parameter int TIMEOUT  = 15
) (
  input  wire           Clock,
  input  wire           Resetn,
  input  wire           Start,
  output logic          Busy,
  output logic          Finished,
`ifdef FEEDER_DONE_TIMEOUT_EN
  output logic          TimeoutErr,
`endif
  proc_feeder_if.master bus
);

  // Reject parameter sets the address space or watchdog cannot support
  if (PROG_LEN < 1 || PROG_LEN > (1 << ADDR_W) || TIMEOUT < 1) begin : g_param_check
    $error("proc_feeder: illegal ADDR_W/PROG_LEN/TIMEOUT combination");
  end

  feeder_state_e     r_state;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_din;
  logic              r_is_mvi;
  logic              r_run;
  logic              r_busy;
  logic              r_finished;

  logic [ADDR_W-1:0] w_pc;
  logic              w_pc_tc;
  logic              w_pc_clr;
  logic              w_pc_inc;
  logic [2:0]        w_op;
  logic              w_is_mvi;
  logic              w_is_unsup;
  logic              w_wd_expired;

  // Opcode of the word arriving from ROM (valid in LATCH_I)
  assign w_op       = bus.MemData[DATA_W-1 -: 3];
  assign w_is_mvi   = (w_op == c_OP_MVI);
  assign w_is_unsup = op_unsupported(w_op);

  // PC control: clear on (re)start, step to the immediate word for mvi,
  // and step past skipped or completed instructions
  always_comb begin
    w_pc_clr = 1'b0;
    w_pc_inc = 1'b0;
    case (r_state)
      S_IDLE, S_FINISHED: w_pc_clr = Start;
      S_LATCH_I:          w_pc_inc = (w_is_mvi || w_is_unsup) && !w_pc_tc;
      S_WAIT:             w_pc_inc = bus.Done && !w_pc_tc;
      default:            ;
    endcase
  end

  prog_counter #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN)
  ) u_prog_counter (
    .Clock  (Clock),
    .Resetn (Resetn),
    .i_clr  (w_pc_clr),
    .i_inc  (w_pc_inc),
    .o_pc   (w_pc),
    .o_tc   (w_pc_tc)
  );

  // Sequencer: fetch, issue one instruction, hold DIN until Done, advance
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_imm      <= '0;
      r_din      <= '0;
      r_is_mvi   <= 1'b0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_run <= 1'b0;
      case (r_state)
        S_IDLE, S_FINISHED: begin
          if (Start) begin
            r_state    <= S_FETCH_I;
            r_busy     <= 1'b1;
            r_finished <= 1'b0;
            r_din      <= '0;
          end
        end
        S_FETCH_I: begin
          r_state <= S_LATCH_I;
        end
        S_LATCH_I: begin
          r_instr <= bus.MemData;
          if ((w_is_mvi || w_is_unsup) && w_pc_tc) begin
            // mvi without room for its immediate, or a skip at the end
            r_state    <= S_FINISHED;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_din      <= '0;
          end else if (w_is_mvi) begin
            r_state <= S_FETCH_D;
          end else if (w_is_unsup) begin
            r_state <= S_FETCH_I;
          end else begin
            r_is_mvi <= 1'b0;
            r_din    <= bus.MemData;
            r_run    <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_FETCH_D: begin
          r_state <= S_LATCH_D;
        end
        S_LATCH_D: begin
          r_imm    <= bus.MemData;
          r_is_mvi <= 1'b1;
          r_din    <= r_instr;
          r_run    <= 1'b1;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: begin
          // Processor samples DIN in the cycle after Run: immediate or zero
          r_din   <= r_is_mvi ? r_imm : '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.Done) begin
            r_din <= '0;
            if (w_pc_tc) begin
              r_state    <= S_FINISHED;
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
            end else begin
              r_state <= S_FETCH_I;
            end
          end else if (w_wd_expired) begin
            r_state    <= S_FINISHED;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_din      <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FEEDER_DONE_TIMEOUT_EN
  localparam int unsigned        c_WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_timeout_err;

  // Watchdog counts consecutive WAIT cycles, restarting on every new issue
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_wd_expired = (r_state == S_WAIT) && (r_wd_cnt == c_WD_LAST);

  // Sticky error flag, cleared only when a new run is started
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_timeout_err <= 1'b0;
    end else if (w_pc_clr) begin
      r_timeout_err <= 1'b0;
    end else if (w_wd_expired && !bus.Done) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign TimeoutErr = r_timeout_err;
`else
  assign w_wd_expired = 1'b0;
`endif

  assign bus.MemAddr = w_pc;
  assign bus.DIN     = r_din;
  assign bus.Run     = r_run;
  assign Busy        = r_busy;
  assign Finished    = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_proc_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_feeder
// Description : Self-checking bench for proc_feeder. A synchronous ROM and a
//               randomized processor model drive the DUT; a program-level
//               reference model fills a scoreboard of expected issues that a
//               separate monitor consumes whenever Run is seen.
//               Build with FEEDER_DONE_TIMEOUT_EN to exercise the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_feeder;
  import proc_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int PROG_LEN = 32;
  localparam int DATA_W   = 9;
  localparam int TIMEOUT  = 15;

  typedef struct {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] t1;
    int                next_addr;
    bit                last;
  } exp_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b1;
  logic Start  = 1'b0;
  logic Busy;
  logic Finished;
`ifdef FEEDER_DONE_TIMEOUT_EN
  logic TimeoutErr;
`endif

  proc_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [DATA_W-1:0] rom [PROG_LEN];
  exp_t              sb [$];
  int                n_tests  = 0;
  int                n_fail   = 0;
  bit                withhold = 1'b0;

  proc_feeder #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN),
    .DATA_W   (DATA_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Start      (Start),
    .Busy       (Busy),
    .Finished   (Finished),
`ifdef FEEDER_DONE_TIMEOUT_EN
    .TimeoutErr (TimeoutErr),
`endif
    .bus        (bus)
  );

  always #5 Clock = ~Clock;

  // Synchronous program ROM, one cycle read latency
  always @(posedge Clock) bus.MemData <= rom[bus.MemAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: list of issues the program should produce, in order
  task automatic build_expect();
    int                pc;
    logic [DATA_W-1:0] w;
    logic [2:0]        op;
    bit                issued;
    exp_t              e;
    pc = 0;
    sb.delete();
    forever begin
      w = rom[pc];
      op = w[8:6];
      e.instr = w;
      e.t1 = '0;
      e.next_addr = 0;
      e.last = 1'b0;
      issued = 1'b0;
      if (op == c_OP_MVI) begin
        if (pc == PROG_LEN - 1) break;
        pc++;
        e.t1 = rom[pc];
        issued = 1'b1;
      end else if (op < 3'd4) begin
        issued = 1'b1;
      end
      if (pc == PROG_LEN - 1) begin
        if (issued) begin
          e.last = 1'b1;
          sb.push_back(e);
        end
        break;
      end
      pc++;
      if (issued) begin
        e.next_addr = pc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic rand_rom();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < PROG_LEN; i++) begin
      w = DATA_W'($urandom);
      if ($urandom_range(0, 4) != 0) w[8] = 1'b0;
      rom[i] = w;
    end
  endtask

  task automatic skip_rom();
    for (int i = 0; i < PROG_LEN; i++) rom[i] = {1'b1, 8'($urandom)};
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("start_memaddr0", 32'(bus.MemAddr), 0);
    chk("start_busy", 32'(Busy), 1);
    chk("start_finished_clr", 32'(Finished), 0);
`ifdef FEEDER_DONE_TIMEOUT_EN
    chk("start_timeout_err_clr", 32'(TimeoutErr), 0);
`endif
  endtask

  task automatic run_program();
    int cyc;
    build_expect();
    pulse_start();
    cyc = 0;
    while (!Finished && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
    end
    chk("finish_reached", 32'(Finished), 1);
    @(negedge Clock);
    chk("all_issued", 32'(sb.size()), 0);
    chk("finished_din0", 32'(bus.DIN), 0);
    chk("finished_busy0", 32'(Busy), 0);
    chk("finished_run0", 32'(bus.Run), 0);
  endtask

  task automatic wait_run();
    int cyc;
    cyc = 0;
    while (!bus.Run && cyc < 200) begin
      @(negedge Clock);
      cyc++;
    end
    chk("run_seen", 32'(bus.Run), 1);
  endtask

  // Processor model: Done a random number of cycles after Run (longer for
  // add/sub), with an occasional Done during the issue cycle that must be ignored
  initial begin : proc_model
    int d;
    bus.Done = 1'b0;
    forever begin
      @(posedge Clock);
      #2;
      bus.Done = 1'b0;
      if (bus.Run && Resetn && !withhold) begin
        bus.Done = ($urandom_range(0, 3) == 0);
        d = $urandom_range(0, 3) +
            ((bus.DIN[8:6] == c_OP_ADD || bus.DIN[8:6] == c_OP_SUB) ? 2 : 0);
        repeat (d) begin
          @(posedge Clock);
          #2;
          bus.Done = 1'b0;
        end
        @(posedge Clock);
        #2;
        bus.Done = !withhold;
      end
    end
  end

  // Monitor: pops the scoreboard on every Run and follows the instruction to Done
  initial begin : monitor
    exp_t cur;
    bit   outstanding;
    bit   chk_next;
    outstanding = 1'b0;
    chk_next    = 1'b0;
    cur.instr = '0;
    cur.t1 = '0;
    cur.next_addr = 0;
    cur.last = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        outstanding = 1'b0;
        chk_next    = 1'b0;
      end else begin
        if (chk_next) begin
          chk_next = 1'b0;
          if (cur.last) begin
            chk("finished_after_last", 32'(Finished), 1);
            chk("busy_after_last", 32'(Busy), 0);
          end else begin
            chk("fetch_addr_after_done", 32'(bus.MemAddr), 32'(cur.next_addr));
            chk("busy_in_fetch", 32'(Busy), 1);
          end
        end
        if (bus.Run) begin
          if (outstanding) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_before_done: Run=1 while previous instruction awaits Done");
          end
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_run: Run=1 DIN=%0h, expected no issue", bus.DIN);
            outstanding = 1'b0;
          end else begin
            cur = sb.pop_front();
            chk("issue_din", 32'(bus.DIN), 32'(cur.instr));
            chk("busy_in_issue", 32'(Busy), 1);
            outstanding = 1'b1;
          end
        end else if (outstanding) begin
          chk("wait_din", 32'(bus.DIN), 32'(cur.t1));
          if (bus.Done) begin
            outstanding = 1'b0;
            chk_next    = 1'b1;
          end
        end
        if (Finished) outstanding = 1'b0;
      end
    end
  end

  initial begin : main
    // Reset state
    #1 Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_memaddr", 32'(bus.MemAddr), 0);
    chk("rst_din", 32'(bus.DIN), 0);
    chk("rst_run", 32'(bus.Run), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_finished", 32'(Finished), 0);
    Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    chk("idle_no_busy", 32'(Busy), 0);

    // mvi R0,#5 at address 0
    rand_rom();
    rom[0] = 9'b001000000;
    rom[1] = 9'd5;
    run_program();

    // mv R1,R0 at address 0
    rand_rom();
    rom[0] = 9'b000001000;
    run_program();

    // add/sub/add/sub then nothing but skipped words
    skip_rom();
    rom[0] = 9'b010000001;
    rom[1] = 9'b011001000;
    rom[2] = 9'b010010011;
    rom[3] = 9'b011011010;
    run_program();

    // Unsupported opcode 101 at address 3 between plain moves
    rand_rom();
    rom[0] = 9'b000001000;
    rom[1] = 9'b000010001;
    rom[2] = 9'b000011010;
    rom[3] = 9'b101000000;
    rom[4] = 9'b000100011;
    run_program();

    // mvi at the last address: never issued; then restart from FINISHED
    skip_rom();
    rom[PROG_LEN-1] = 9'b001111000;
    run_program();
    run_program();

    // Random programs
    for (int k = 0; k < 6; k++) begin
      rand_rom();
      run_program();
    end

    // Reset while holding an mvi immediate in WAIT
    withhold = 1'b1;
    rand_rom();
    rom[0] = 9'b001010000;
    rom[1] = 9'h1A5;
    build_expect();
    pulse_start();
    wait_run();
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("rst_wait_din", 32'(bus.DIN), 0);
    chk("rst_wait_run", 32'(bus.Run), 0);
    chk("rst_wait_busy", 32'(Busy), 0);
    chk("rst_wait_memaddr", 32'(bus.MemAddr), 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;

    // Reset during the issue cycle drops Run immediately
    build_expect();
    pulse_start();
    wait_run();
    #2 Resetn = 1'b0;
    #1;
    chk("rst_issue_run", 32'(bus.Run), 0);
    chk("rst_issue_din", 32'(bus.DIN), 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    sb.delete();
    withhold = 1'b0;
    repeat (10) @(negedge Clock);

`ifdef FEEDER_DONE_TIMEOUT_EN
    // Done withheld: watchdog finishes the run after TIMEOUT WAIT cycles
    withhold = 1'b1;
    rand_rom();
    rom[0] = 9'b000001000;
    build_expect();
    pulse_start();
    wait_run();
    repeat (TIMEOUT) @(negedge Clock);
    chk("no_finish_before_timeout", 32'(Finished), 0);
    @(negedge Clock);
    chk("timeout_finished", 32'(Finished), 1);
    chk("timeout_err_set", 32'(TimeoutErr), 1);
    chk("timeout_busy0", 32'(Busy), 0);
    sb.delete();
    withhold = 1'b0;
    repeat (10) @(negedge Clock);
    rand_rom();
    run_program();
    chk("timeout_err_stays_clr", 32'(TimeoutErr), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL global_timeout: simulation ran %0t without completing", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "bench watchdog expired");
  end

endmodule
`default_nettype wire
